trace_pkt_unpack: RTL and testbench

//  Receiving end of the core's per-cycle retire trace packet (up to 3 retire slots per cycle).

---
 rtl/trace_pkt_unpack.sv | 143 ++++++++++++++
 tb/tb_trace_pkt_unpack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_pkt_unpack.sv
// Retire trace unpacker: compacts up to three retire slots per cycle
// into a record FIFO; a packet that does not fit is dropped and counted.
module trace_pkt_unpack #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            trace_rv_i_valid_ip,
  input  logic [95:0]           trace_rv_i_insn_ip,
  input  logic [95:0]           trace_rv_i_address_ip,
  input  logic [2:0]            trace_rv_i_exception_ip,
  input  logic [4:0]            trace_rv_i_ecause_ip,
  input  logic [2:0]            trace_rv_i_interrupt_ip,
  input  logic [31:0]           trace_rv_i_tval_ip,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_insn,
  output logic [31:0]           out_addr,
  output logic                  out_exc,
  output logic                  out_intr,
  output logic [4:0]            out_ecause,
  output logic [31:0]           out_tval,
  output logic                  out_gap,
  output logic                  ovf_sticky,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        gap;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_gap_pend;

  logic [AW:0]   w_n;
  logic [AW:0]   w_free;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [AW-1:0] w_off [3];
  rec_t          w_rec [3];
  rec_t          w_head;
  logic [DROP_CNT_W:0] w_sum;

  assign w_n = (AW+1)'(trace_rv_i_valid_ip[0])
             + (AW+1)'(trace_rv_i_valid_ip[1])
             + (AW+1)'(trace_rv_i_valid_ip[2]);
  assign w_free = (AW+1)'(DEPTH) - r_cnt;
  // room is judged on the start-of-cycle count; a same-cycle pop is ignored
  assign w_push = (w_n != '0) && (w_n <= w_free);
  assign w_drop = (w_n != '0) && !w_push;
  assign w_pop  = out_valid & out_ready;
  assign w_sum  = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(w_n);

  assign w_off[0] = '0;
  assign w_off[1] = AW'(trace_rv_i_valid_ip[0]);
  assign w_off[2] = AW'(trace_rv_i_valid_ip[0])
                  + AW'(trace_rv_i_valid_ip[1]);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_rec[k].insn   = trace_rv_i_insn_ip[32*k +: 32];
      w_rec[k].addr   = trace_rv_i_address_ip[32*k +: 32];
      w_rec[k].exc    = trace_rv_i_exception_ip[k];
      w_rec[k].intr   = trace_rv_i_interrupt_ip[k];
      w_rec[k].ecause = (trace_rv_i_exception_ip[k] |
                         trace_rv_i_interrupt_ip[k]) ?
                        trace_rv_i_ecause_ip : 5'd0;
      w_rec[k].tval   = trace_rv_i_exception_ip[k] ?
                        trace_rv_i_tval_ip : 32'd0;
      w_rec[k].gap    = r_gap_pend && (w_off[k] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < 3; k++) begin
        if (trace_rv_i_valid_ip[k])
          r_mem[r_wr + w_off[k]] <= w_rec[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_gap_pend <= 1'b0;
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + (w_push ? w_n : '0) - (AW+1)'(w_pop);
      if (w_push)
        r_wr <= r_wr + w_n[AW-1:0];
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_drop)
        r_gap_pend <= 1'b1;
      else if (w_push)
        r_gap_pend <= 1'b0;
      if (w_drop)
        ovf_sticky <= 1'b1;
      else if (clr_ovf)
        ovf_sticky <= 1'b0;
      if (w_drop) begin
        if (clr_ovf)
          drop_cnt <= DROP_CNT_W'(w_n);
        else if (w_sum[DROP_CNT_W])
          drop_cnt <= '1;
        else
          drop_cnt <= w_sum[DROP_CNT_W-1:0];
      end else if (clr_ovf) begin
        drop_cnt <= '0;
      end
    end
  end

  // data is forced to zero whenever nothing is buffered
  assign out_valid  = (r_cnt != '0);
  assign w_head     = r_mem[r_rd];
  assign out_insn   = out_valid ? w_head.insn   : 32'd0;
  assign out_addr   = out_valid ? w_head.addr   : 32'd0;
  assign out_exc    = out_valid ? w_head.exc    : 1'b0;
  assign out_intr   = out_valid ? w_head.intr   : 1'b0;
  assign out_ecause = out_valid ? w_head.ecause : 5'd0;
  assign out_tval   = out_valid ? w_head.tval   : 32'd0;
  assign out_gap    = out_valid ? w_head.gap    : 1'b0;

endmodule

// File: tb/tb_trace_pkt_unpack.sv
// Scoreboard bench for trace_pkt_unpack: directed packets queue their
// expected records; a negedge monitor checks every presented record.
module tb_trace_pkt_unpack;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ec;
    logic [31:0] tv;
    logic        gap;
  } rec_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  valid_ip = 0;
  logic [95:0] insn_ip = 0;
  logic [95:0] addr_ip = 0;
  logic [2:0]  exc_ip = 0;
  logic [4:0]  ec_ip = 0;
  logic [2:0]  intr_ip = 0;
  logic [31:0] tval_ip = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        out_exc;
  logic        out_intr;
  logic [4:0]  out_ecause;
  logic [31:0] out_tval;
  logic        out_gap;
  logic        ovf_sticky;
  logic [15:0] drop_cnt;
  logic        clr_ovf = 0;

  rec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  trace_pkt_unpack #(.DEPTH(8), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .trace_rv_i_valid_ip(valid_ip),
    .trace_rv_i_insn_ip(insn_ip),
    .trace_rv_i_address_ip(addr_ip),
    .trace_rv_i_exception_ip(exc_ip),
    .trace_rv_i_ecause_ip(ec_ip),
    .trace_rv_i_interrupt_ip(intr_ip),
    .trace_rv_i_tval_ip(tval_ip),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr),
    .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval),
    .out_gap(out_gap), .ovf_sticky(ovf_sticky),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ex/it/ec/tv are applied as given; the expected record keeps ecause
  // only for exc|intr and tval only for exc
  task automatic send(input logic [2:0] v, input logic [95:0] ins,
                      input logic [95:0] ad, input logic [2:0] ex,
                      input logic [2:0] it, input logic [4:0] ec,
                      input logic [31:0] tv, input bit acc,
                      input bit g);
    bit   first;
    rec_t r;
    first = 1;
    valid_ip = v; insn_ip = ins; addr_ip = ad;
    exc_ip = ex; intr_ip = it; ec_ip = ec; tval_ip = tv;
    if (acc) begin
      for (int k = 0; k < 3; k++) begin
        if (v[k]) begin
          r.insn = ins[32*k +: 32];
          r.addr = ad[32*k +: 32];
          r.exc  = ex[k];
          r.intr = it[k];
          r.ec   = (ex[k] | it[k]) ? ec : 5'd0;
          r.tv   = ex[k] ? tv : 32'd0;
          r.gap  = first ? g : 1'b0;
          first  = 0;
          q.push_back(r);
        end
      end
    end
    cycle();
    valid_ip = 0; exc_ip = 0; intr_ip = 0;
  endtask

  task automatic send3(input logic [31:0] base, input bit acc,
                       input bit g);
    send(3'b111, {base + 32'd2, base + 32'd1, base},
         {32'h200 + base, 32'h100 + base, base}, 3'b0, 3'b0,
         5'd0, 32'd0, acc, g);
  endtask

  task automatic drain();
    int t;
    out_ready = 1;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      cycle();
      t++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
  endtask

  initial begin : monitor
    rec_t got;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        n_chk++;
        got = {out_insn, out_addr, out_exc, out_intr,
               out_ecause, out_tval, out_gap};
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rec_extra: got insn=%h addr=%h required none",
                   out_insn, out_addr);
        end else begin
          if (got !== q[0]) begin
            n_fail++;
            $display("FAIL rec: got insn=%h addr=%h exc=%b intr=%b ec=%0d tval=%h gap=%b required insn=%h addr=%h exc=%b intr=%b ec=%0d tval=%h gap=%b",
                     got.insn, got.addr, got.exc, got.intr, got.ec,
                     got.tv, got.gap, q[0].insn, q[0].addr, q[0].exc,
                     q[0].intr, q[0].ec, q[0].tv, q[0].gap);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    n_fail++;
    $display("FAIL watchdog: got timeout required finish");
    summary();
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sent;
    int t;
    repeat (3) cycle();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_insn", out_insn, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_drop", drop_cnt, 0);

    // basic three-slot packet, one cycle latency
    out_ready = 1;
    send(3'b111, {32'hC, 32'hB, 32'hA}, {32'h108, 32'h104, 32'h100},
         3'b0, 3'b0, 5'd0, 32'd0, 1, 0);
    chk("lat_valid", out_valid, 1);
    chk("lat_insn", out_insn, 32'hA);
    drain();

    // compaction, exception and interrupt fields
    send(3'b101, {32'h33, 32'h22, 32'h11}, {32'h308, 32'h304, 32'h300},
         3'b001, 3'b000, 5'd2, 32'hDEAD, 1, 0);
    send(3'b010, {32'h66, 32'h55, 32'h44}, {32'h408, 32'h404, 32'h400},
         3'b000, 3'b010, 5'd7, 32'h55, 1, 0);
    send(3'b110, {32'h99, 32'h88, 32'h77}, {32'h508, 32'h504, 32'h500},
         3'b100, 3'b010, 5'd9, 32'hBEEF, 1, 0);
    drain();

    // overflow drops whole packet, gap marks next record
    out_ready = 0;
    send3(32'h1000, 1, 0);
    send3(32'h1010, 1, 0);
    send3(32'h1020, 0, 0);
    chk("ovf_set", ovf_sticky, 1);
    chk("drop3", drop_cnt, 3);
    send(3'b011, {32'h0, 32'h1031, 32'h1030}, {32'h0, 32'h4, 32'h8},
         3'b0, 3'b0, 5'd0, 32'd0, 1, 1);
    send(3'b001, {64'h0, 32'h1040}, 96'h0, 3'b0, 3'b0, 5'd0, 32'd0, 0, 0);
    chk("drop_full", drop_cnt, 4);
    drain();

    // same-cycle pop gives no extra room
    out_ready = 0;
    send3(32'h2000, 1, 1);
    send3(32'h2010, 1, 0);
    send(3'b001, {64'h0, 32'h2020}, 96'h0, 3'b0, 3'b0, 5'd0, 32'd0, 1, 0);
    out_ready = 1;
    send(3'b001, {64'h0, 32'h2030}, 96'h0, 3'b0, 3'b0, 5'd0, 32'd0, 1, 0);
    out_ready = 1;
    send(3'b011, {32'h0, 32'h2041, 32'h2040}, 96'h0, 3'b0, 3'b0,
         5'd0, 32'd0, 0, 0);
    out_ready = 0;
    chk("drop_pop2", drop_cnt, 6);
    send(3'b011, {32'h0, 32'h2051, 32'h2050}, 96'h0, 3'b0, 3'b0,
         5'd0, 32'd0, 1, 1);
    send(3'b001, {64'h0, 32'h2060}, 96'h0, 3'b0, 3'b0, 5'd0, 32'd0, 0, 0);
    chk("drop_cnt6", drop_cnt, 7);
    drain();

    // saturation and clear-vs-drop priority
    clr_ovf = 1;
    cycle();
    clr_ovf = 0;
    chk("clr_ovf", ovf_sticky, 0);
    chk("clr_drop", drop_cnt, 0);
    out_ready = 0;
    send3(32'h3000, 1, 1);
    send3(32'h3010, 1, 0);
    send(3'b011, {32'h0, 32'h3021, 32'h3020}, 96'h0, 3'b0, 3'b0,
         5'd0, 32'd0, 1, 0);
    for (int i = 0; i < 100; i++) send3(32'h3100, 0, 0);
    chk("drop300", drop_cnt, 300);
    for (int i = 0; i < 21746; i++) send3(32'h3100, 0, 0);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    chk("ovf_sat", ovf_sticky, 1);
    clr_ovf = 1;
    send3(32'h3200, 0, 0);
    clr_ovf = 0;
    chk("clr_drop_ovf", ovf_sticky, 1);
    chk("clr_drop_cnt", drop_cnt, 3);
    clr_ovf = 1;
    cycle();
    clr_ovf = 0;
    chk("clr2_ovf", ovf_sticky, 0);
    chk("clr2_drop", drop_cnt, 0);
    drain();

    // wrap with random backpressure, never exceeding free space
    sent = 0;
    t = 0;
    while (sent < 25 && t < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent == 24 && q.size() + 1 <= 8) begin
        send(3'b001, {64'h0, 32'h5000 + sent}, {64'h0, 32'h8000 + 4 * sent},
             3'b0, 3'b0, 5'd0, 32'd0, 1, 0);
        sent += 1;
      end else if (sent < 24 && q.size() + 3 <= 8) begin
        send(3'b111,
             {32'h5000 + sent + 2, 32'h5000 + sent + 1, 32'h5000 + sent},
             {32'h8000 + 4 * (sent + 2), 32'h8000 + 4 * (sent + 1),
              32'h8000 + 4 * sent},
             3'b0, 3'b0, 5'd0, 32'd0, 1, sent == 0);
        sent += 3;
      end else begin
        cycle();
      end
      t++;
    end
    chk("wrap_sent", sent, 25);
    drain();
    chk("wrap_ovf", ovf_sticky, 0);

    // reset mid-stream discards buffered records
    out_ready = 0;
    send3(32'h6000, 1, 0);
    rst = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    q.delete();
    cycle();
    cycle();
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("post_rst_valid", out_valid, 0);
    end

    summary();
    $finish;
  end

endmodule
